// File: rtl/counter_scheduler_pkg.sv
// Shared types for the counter scheduler: FSM state encoding and direction codes.
package counter_sched_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side bus of the counter scheduler: requests in, grant/status/completion out.
interface counter_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_len;
   logic [N_REQ-1:0]       req_up;
   logic                   abort;
   logic [N_REQ-1:0]       req_ready;
   logic                   busy;
   logic [IDX_W-1:0]       owner;
   logic [WIDTH-1:0]       cnt;
   logic [N_REQ-1:0]       done;

   modport master (
      output req_valid, req_len, req_up, abort,
      input  req_ready, busy, owner, cnt, done
   );

   modport slave (
      input  req_valid, req_len, req_up, abort,
      output req_ready, busy, owner, cnt, done
   );
endinterface

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);
   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      // Offsets 1..N_REQ; offset N_REQ lands back on 'last' so it is served last.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(idx);
         end
      end
      if (found) grant = N_REQ'(1) << grant_idx;
   end
endmodule

// File: rtl/counter_scheduler.sv
// Shares one up/down interval counter among N_REQ requesters; round-robin grant, IDLE/RUN/DONE FSM.
module counter_scheduler
   import counter_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   counter_scheduler_if.slave  bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic             up_q, up_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [N_REQ-1:0] done_q, done_d;

   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic [WIDTH-1:0] sel_len;
   logic [WIDTH-1:0] terminal;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req       (bus.req_valid),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_len = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) sel_len = bus.req_len[i*WIDTH +: WIDTH];
   end

   assign terminal = (up_q == DIR_UP) ? len_q : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      up_d    = up_q;
      owner_d = owner_q;
      last_d  = last_q;
      done_d  = '0;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               len_d   = sel_len;
               up_d    = bus.req_up[grant_idx];
               owner_d = grant_idx;
               cnt_d   = (bus.req_up[grant_idx] == DIR_DOWN) ? sel_len : '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // abort outranks the terminal check, so an aborted interval never pulses done.
            if (bus.abort) begin
               state_d = IDLE;
               last_d  = owner_q;
            end else if (cnt_q == terminal) begin
               state_d = DONE;
               done_d  = N_REQ'(1) << owner_q;
            end else begin
               cnt_d = (up_q == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            last_d  = owner_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         up_q    <= DIR_UP;
         owner_q <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         up_q    <= up_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE) ? grant : '0;
   assign bus.busy      = (state_q != IDLE);
   assign bus.owner     = owner_q;
   assign bus.cnt       = cnt_q;
   assign bus.done      = done_q;
endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Time-shares one programmable up/down interval counter among N_REQ requesters.
- Each requester asks for an interval of length len in a chosen direction.
- A round-robin arbiter grants the counter, and a 3-state FSM runs the count and returns a one-cycle done pulse to the owner.
- Sits above the team's counter primitives as their sequencing/sharing controller.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, counter and length width in bits
IDX_W, $clog2(N_REQ), owner index width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request, held until accepted
req_len  input  N_REQ*WIDTH  requester i length in bits [i*WIDTH +: WIDTH]
req_up  input  N_REQ  1 = count 0 up to len; 0 = count len down to 0
abort  input  1  cancels current interval
req_ready  output  N_REQ  one-hot accept strobe (combinational, IDLE only)
busy  output  1  high when state != IDLE
owner  output  IDX_W  index of current/last granted requester (registered)
cnt  output  WIDTH  live counter value (registered)
done  output  N_REQ  one-hot, one-cycle completion pulse (registered)

Behaviour:
- Reset values: state IDLE, cnt 0, owner 0, done 0, busy 0, last_grant N_REQ-1, so requester 0 has first priority.
- States: IDLE, RUN, DONE.
- IDLE:
  - winner = first i with req_valid[i], searching last_grant+1, last_grant+2, … modulo N_REQ.
  - req_ready[winner]=1 in the same cycle; all other bits 0. No valid requests -> req_ready all 0.
  - On acceptance (cycle T): latch len_r=req_len slice, up_r=req_up[winner], owner=winner.
  - Load cnt = up_r ? 0 : len_r. Next state RUN.
- RUN:
  - terminal = up_r ? len_r : 0.
  - cnt == terminal -> next DONE, cnt holds.
  - Otherwise cnt steps by ±1 (no wrap possible, as terminal bounds the count).
- Timing for len L:
  - RUN occupies cycles T+1..T+L+1 (L+1 cycles; cnt shows start value at T+1).
  - DONE is at T+L+2, with done[owner]=1 in that cycle only.
  - IDLE at T+L+3; the next acceptance is earliest T+L+3.
- len=0: one RUN cycle with cnt=0, then DONE.
- DONE: set last_grant=owner, go IDLE. cnt keeps its final value until the next load.
- abort:
  - Sampled in RUN or DONE, and takes priority over the terminal check.
  - Next state IDLE, no done pulse (a done pulse already driven in the current DONE cycle still stands).
  - last_grant=owner, cnt holds.
  - Ignored in IDLE.
- Requests:
  - req_valid deasserted before acceptance is simply dropped; no latching of unaccepted requests.
  - req_len/req_up are only sampled in the acceptance cycle; changes afterward have no effect.
  - The owner may re-request immediately; it regains the grant only after every other valid requester has been served (round-robin).
- rst mid-interval: returns to reset values on the next edge, with no done pulse.

Decomposition:
- Package counter_sched_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - localparam DIR_UP=1'b1, DIR_DOWN=1'b0.
- Sub-module rr_arbiter (parameters N_REQ): inputs req[N], last[IDX_W]; outputs grant one-hot and grant_idx; purely combinational.
- The FSM and datapath stay in counter_scheduler.

Test Plan:
- Reset, then valid[0] with len=3, up=1, accepted at T:
  - cnt 0,1,2,3 over T+1..T+4;
  - done=0001 at T+5;
  - busy low at T+6.
- Requester 2 with len=4, up=0:
  - cnt 4,3,2,1,0;
  - done[2] pulses once;
  - owner=2 throughout.
- All four valid continuously with len=1:
  - grants in order 0,1,2,3,0;
  - each done pulse one-hot matching the grant;
  - no requester starved.
- len=0, up=1:
  - one RUN cycle with cnt=0;
  - done pulse 2 cycles after acceptance.
- abort during RUN of a len=10 interval at cnt=5:
  - IDLE next cycle, no done pulse, cnt holds 5;
  - next grant goes to owner+1 when valid.
- rst asserted mid-RUN:
  - next cycle cnt=0, busy=0, done=0;
  - the first subsequent grant goes to requester 0.
